// File: rtl/train_sequencer_pkg.sv
// train_sequencer_pkg: shared defaults and FSM state encoding for the training sequencer
package train_sequencer_pkg;
    localparam int NUM_SAMPLES_DEF = 332;
    localparam int MAX_ITER_DEF = 10000;
    localparam int ADDR_W_DEF = 16;
    localparam int CNT_W_DEF = 16;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/train_sequencer_mod_counter.sv
// mod_counter: modulo-LIMIT counter with clear, increment and a wrap flag at LIMIT-1
module mod_counter
    import train_sequencer_pkg::*;
#(
    parameter int WIDTH = ADDR_W_DEF,
    parameter int LIMIT = NUM_SAMPLES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);
    logic [WIDTH-1:0] count_d, count_q;
    assign wrap = count_q == WIDTH'(LIMIT - 1);
    assign count = count_q;
    // clear wins over increment; increment past LIMIT-1 returns to zero
    always_comb begin
        count_d = count_q;
        if (clr) count_d = '0;
        else if (inc) count_d = wrap ? '0 : count_q + WIDTH'(1);
    end
    // count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else count_q <= count_d;
    end
endmodule

// File: rtl/train_sequencer.sv
// train_sequencer: issues sample indices to the datapath and counts iterations/epochs
module train_sequencer
    import train_sequencer_pkg::*;
#(
    parameter int NUM_SAMPLES = NUM_SAMPLES_DEF,
    parameter int MAX_ITER = MAX_ITER_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] sample_addr,
    output logic              sample_valid,
    input  logic              sample_ready,
    input  logic              update_done,
    output logic [CNT_W-1:0]  iter_count,
    output logic [CNT_W-1:0]  epoch_count,
    output logic              busy,
    output logic              training_done
);
    state_t state_d, state_q;
    logic [CNT_W-1:0] iter_d, iter_q, epoch_d, epoch_q, iter_inc, epoch_inc;
    logic valid_d, valid_q, busy_d, busy_q, done_d, done_q;
    logic go, upd, addr_clr, addr_inc, addr_wrap;
    assign go = start && !abort && (state_q == IDLE || state_q == DONE);
    assign upd = update_done && !abort && state_q == WAIT;
    assign iter_inc = &iter_q ? iter_q : iter_q + CNT_W'(1);
    assign epoch_inc = &epoch_q ? epoch_q : epoch_q + CNT_W'(1);
    mod_counter #(.WIDTH(ADDR_W), .LIMIT(NUM_SAMPLES)) u_addr (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (addr_clr),
        .inc  (addr_inc),
        .count(sample_addr),
        .wrap (addr_wrap)
    );
    // next state and counter updates; abort overrides everything but leaves counters alone
    always_comb begin
        state_d = state_q;
        iter_d = iter_q;
        epoch_d = epoch_q;
        addr_clr = 1'b0;
        addr_inc = 1'b0;
        if (abort) state_d = IDLE;
        else if (go) begin
            state_d = ISSUE;
            iter_d = '0;
            epoch_d = '0;
            addr_clr = 1'b1;
        end else if (state_q == ISSUE && sample_ready) state_d = WAIT;
        else if (upd) begin
            iter_d = iter_inc;
            epoch_d = addr_wrap ? epoch_inc : epoch_q;
            addr_inc = 1'b1;
            state_d = (iter_inc == CNT_W'(MAX_ITER)) ? DONE : ISSUE;
        end
        valid_d = state_d == ISSUE;
        busy_d = state_d == ISSUE || state_d == WAIT;
        done_d = state_d == DONE;
    end
    // state, counters and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            iter_q <= '0;
            epoch_q <= '0;
            valid_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            iter_q <= iter_d;
            epoch_q <= epoch_d;
            valid_q <= valid_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end
    assign sample_valid = valid_q;
    assign busy = busy_q;
    assign training_done = done_q;
    assign iter_count = iter_q;
    assign epoch_count = epoch_q;
endmodule

// File: tb/tb_train_sequencer.sv
// tb_train_sequencer: directed self-checking bench for train_sequencer (4 samples, 10 iterations)
module tb_train_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic sample_ready = 1'b0;
    logic update_done = 1'b0;
    logic [15:0] sample_addr, iter_count, epoch_count;
    logic sample_valid, busy, training_done;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    train_sequencer #(.NUM_SAMPLES(4), .MAX_ITER(10), .ADDR_W(16), .CNT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .sample_addr  (sample_addr),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .update_done  (update_done),
        .iter_count   (iter_count),
        .epoch_count  (epoch_count),
        .busy         (busy),
        .training_done(training_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int v, input int a, input int it,
                           input int ep, input int b, input int d);
        chk({tag, ".valid"}, 32'(sample_valid), 32'(v));
        chk({tag, ".addr"}, 32'(sample_addr), 32'(a));
        chk({tag, ".iter"}, 32'(iter_count), 32'(it));
        chk({tag, ".epoch"}, 32'(epoch_count), 32'(ep));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".done"}, 32'(training_done), 32'(d));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic pulse_done;
        update_done = 1'b1;
        tick;
        update_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) tick;
        chk_out("reset", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        tick;
        chk_out("idle", 0, 0, 0, 0, 0, 0);
        sample_ready = 1'b1;
        pulse_start;
        chk("t1_latency", 32'(sample_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            chk_out($sformatf("t2_issue%0d", i), 1, i % 4, i, i / 4, 1, 0);
            tick;
            chk($sformatf("t2_wait%0d.valid", i), 32'(sample_valid), 32'd0);
            tick;
            tick;
            pulse_done;
        end
        chk_out("t2_done", 0, 2, 10, 2, 0, 1);
        tick;
        pulse_done;
        chk_out("t2_frozen", 0, 2, 10, 2, 0, 1);
        sample_ready = 1'b0;
        pulse_start;
        chk_out("t6_restart", 1, 0, 0, 0, 1, 0);
        for (int k = 0; k < 5; k++) begin
            tick;
            chk_out($sformatf("t3_hold%0d", k), 1, 0, 0, 0, 1, 0);
        end
        pulse_done;
        chk_out("t4_done_in_issue", 1, 0, 0, 0, 1, 0);
        pulse_start;
        chk_out("t4_start_in_issue", 1, 0, 0, 0, 1, 0);
        sample_ready = 1'b1;
        tick;
        chk_out("t3_accept", 0, 0, 0, 0, 1, 0);
        for (int j = 0; j < 7; j++) begin
            pulse_done;
            tick;
        end
        chk_out("t5_wait7", 0, 3, 7, 1, 1, 0);
        pulse_start;
        chk_out("t4_start_in_wait", 0, 3, 7, 1, 1, 0);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk_out("t5_abort", 0, 3, 7, 1, 0, 0);
        pulse_done;
        chk_out("t4_done_in_idle", 0, 3, 7, 1, 0, 0);
        start = 1'b1;
        abort = 1'b1;
        tick;
        start = 1'b0;
        abort = 1'b0;
        chk_out("t5_start_abort", 0, 3, 7, 1, 0, 0);
        pulse_start;
        chk_out("t5_restart", 1, 0, 0, 0, 1, 0);
        tick;
        pulse_done;
        tick;
        chk_out("t6_pre_rst", 0, 1, 1, 0, 1, 0);
        update_done = 1'b1;
        rst_n = 1'b0;
        #1;
        chk_out("t6_async_rst", 0, 0, 0, 0, 0, 0);
        tick;
        update_done = 1'b0;
        rst_n = 1'b1;
        tick;
        chk_out("t6_after_rst", 0, 0, 0, 0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
